// File: rtl/craps_pkg.sv
// rtl/craps_pkg.sv - state encoding and sum/die helper functions for the craps session controller
package craps_pkg;

    localparam int STATE_W = 4;

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] CO_ROLL   = 4'd1;
    localparam logic [3:0] CO_EVAL   = 4'd2;
    localparam logic [3:0] PT_WAIT   = 4'd3;
    localparam logic [3:0] PT_ROLL   = 4'd4;
    localparam logic [3:0] PT_EVAL   = 4'd5;
    localparam logic [3:0] WIN_HOLD  = 4'd6;
    localparam logic [3:0] WIN       = 4'd7;
    localparam logic [3:0] LOSE_HOLD = 4'd8;
    localparam logic [3:0] LOSE      = 4'd9;
    localparam logic [3:0] BROKE     = 4'd10;

    typedef enum logic [3:0] {
        ST_IDLE      = IDLE,
        ST_CO_ROLL   = CO_ROLL,
        ST_CO_EVAL   = CO_EVAL,
        ST_PT_WAIT   = PT_WAIT,
        ST_PT_ROLL   = PT_ROLL,
        ST_PT_EVAL   = PT_EVAL,
        ST_WIN_HOLD  = WIN_HOLD,
        ST_WIN       = WIN,
        ST_LOSE_HOLD = LOSE_HOLD,
        ST_LOSE      = LOSE,
        ST_BROKE     = BROKE
    } state_t;

    function automatic int nat_sum(input int sides);
        return sides + 1;
    endfunction

    function automatic int yo_sum(input int sides);
        return 2 * sides - 1;
    endfunction

    function automatic logic is_craps(input int sum, input int sides);
        return (sum == 2) || (sum == 3) || (sum == 2 * sides);
    endfunction

    function automatic logic die_valid(input int d, input int sides);
        return (d >= 1) && (d <= sides);
    endfunction

endpackage

// File: rtl/craps_outcome.sv
// rtl/craps_outcome.sv - combinational roll classifier shared by the come-out and point evaluations
import craps_pkg::*;

module craps_outcome #(
    parameter int SIDES = 6,
    parameter int SUM_W = $clog2(2 * SIDES + 1)
) (
    input  logic [SUM_W-1:0] sum,
    input  logic [SUM_W-1:0] point,
    input  logic             phase,
    output logic             win_hit,
    output logic             lose_hit,
    output logic             set_point
);

    // phase 0 = come-out roll, phase 1 = trying to make the point
    always_comb begin
        win_hit   = 1'b0;
        lose_hit  = 1'b0;
        set_point = 1'b0;
        if (!phase) begin
            if ((int'(sum) == nat_sum(SIDES)) || (int'(sum) == yo_sum(SIDES))) begin
                win_hit = 1'b1;
            end else if (is_craps(int'(sum), SIDES)) begin
                lose_hit = 1'b1;
            end else begin
                set_point = 1'b1;
            end
        end else begin
            if (sum == point) begin
                win_hit = 1'b1;
            end else if (int'(sum) == nat_sum(SIDES)) begin
                lose_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/craps_session.sv
// rtl/craps_session.sv - multi-game craps controller with bankroll and statistics
import craps_pkg::*;

module craps_session #(
    parameter int SIDES        = 6,
    parameter int CREDITS_INIT = 10,
    parameter int BET          = 1,
    parameter int CRED_W       = 8,
    parameter int CNT_W        = 8,
    localparam int DIE_W       = $clog2(SIDES + 1),
    localparam int SUM_W       = $clog2(2 * SIDES + 1)
) (
    input  logic              CLK10KHZ,
    input  logic              reset,
    input  logic              btn,
    input  logic [DIE_W-1:0]  die1,
    input  logic [DIE_W-1:0]  die2,
    output logic [3:0]        state,
    output logic [SUM_W-1:0]  sum_q,
    output logic [SUM_W-1:0]  point,
    output logic              point_valid,
    output logic              play,
    output logic              win,
    output logic              lose,
    output logic              broke,
    output logic              roll_err,
    output logic [CRED_W-1:0] credits,
    output logic [CNT_W-1:0]  games,
    output logic [CNT_W-1:0]  wins,
    output logic [CNT_W-1:0]  losses,
    output logic [CNT_W-1:0]  rolls
);

    localparam logic [CRED_W-1:0] CRED_MAX = '1;
    localparam logic [CRED_W:0]   BET_X    = (CRED_W + 1)'(BET);

    state_t             state_q;
    state_t             state_d;
    logic               btn_q;
    logic               roll_ok;
    logic [SUM_W-1:0]   roll_sum;
    logic               can_bet;
    logic               btn_rise;
    logic               win_hit;
    logic               lose_hit;
    logic               set_point;
    logic               take_roll;
    logic               bad_roll;
    logic               set_pt;
    logic               book_win;
    logic               book_lose;
    logic               enter_idle;
    logic [CRED_W:0]    cred_up;
    logic [CRED_W-1:0]  cred_win;
    logic [CRED_W-1:0]  cred_lose;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign roll_ok  = die_valid(int'(die1), SIDES) && die_valid(int'(die2), SIDES);
    assign roll_sum = SUM_W'(die1) + SUM_W'(die2);
    assign can_bet  = ({1'b0, credits} >= BET_X);
    assign btn_rise = btn & ~btn_q;

    // the win path clamps at full scale; the loss path cannot underflow because IDLE refuses to start a game
    assign cred_up   = {1'b0, credits} + BET_X;
    assign cred_win  = (cred_up > {1'b0, CRED_MAX}) ? CRED_MAX : cred_up[CRED_W-1:0];
    assign cred_lose = credits - CRED_W'(BET);

    craps_outcome #(
        .SIDES (SIDES),
        .SUM_W (SUM_W)
    ) u_outcome (
        .sum       (sum_q),
        .point     (point),
        .phase     (state_q == ST_PT_EVAL),
        .win_hit   (win_hit),
        .lose_hit  (lose_hit),
        .set_point (set_point)
    );

    always_ff @(posedge CLK10KHZ or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn;
        end
    end

    always_comb begin
        state_d   = state_q;
        take_roll = 1'b0;
        bad_roll  = 1'b0;
        set_pt    = 1'b0;
        book_win  = 1'b0;
        book_lose = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!can_bet) begin
                    state_d = ST_BROKE;
                end else if (btn) begin
                    state_d = ST_CO_ROLL;
                end
            end
            ST_CO_ROLL: begin
                if (!btn) begin
                    if (roll_ok) begin
                        take_roll = 1'b1;
                        state_d   = ST_CO_EVAL;
                    end else begin
                        bad_roll = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_CO_EVAL: begin
                if (win_hit) begin
                    book_win = 1'b1;
                    state_d  = ST_WIN_HOLD;
                end else if (lose_hit) begin
                    book_lose = 1'b1;
                    state_d   = ST_LOSE_HOLD;
                end else begin
                    set_pt  = set_point;
                    state_d = ST_PT_WAIT;
                end
            end
            ST_PT_WAIT: begin
                if (btn) begin
                    state_d = ST_PT_ROLL;
                end
            end
            ST_PT_ROLL: begin
                if (!btn) begin
                    if (roll_ok) begin
                        take_roll = 1'b1;
                        state_d   = ST_PT_EVAL;
                    end else begin
                        bad_roll = 1'b1;
                        state_d  = ST_PT_WAIT;
                    end
                end
            end
            ST_PT_EVAL: begin
                if (win_hit) begin
                    book_win = 1'b1;
                    state_d  = ST_WIN_HOLD;
                end else if (lose_hit) begin
                    book_lose = 1'b1;
                    state_d   = ST_LOSE_HOLD;
                end else begin
                    state_d = ST_PT_WAIT;
                end
            end
            ST_WIN_HOLD: begin
                if (btn) begin
                    state_d = ST_WIN;
                end
            end
            ST_LOSE_HOLD: begin
                if (btn) begin
                    state_d = ST_LOSE;
                end
            end
            // a fresh press is needed here so the press that left HOLD cannot fall straight through
            ST_WIN, ST_LOSE: begin
                if (btn_rise) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BROKE: begin
                state_d = ST_BROKE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign enter_idle = (state_d == ST_IDLE) && (state_q != ST_IDLE);

    always_ff @(posedge CLK10KHZ or posedge reset) begin
        if (reset) begin
            sum_q       <= '0;
            point       <= '0;
            point_valid <= 1'b0;
            roll_err    <= 1'b0;
            credits     <= CRED_W'(CREDITS_INIT);
            games       <= '0;
            wins        <= '0;
            losses      <= '0;
            rolls       <= '0;
        end else begin
            roll_err <= bad_roll;
            if (take_roll) begin
                sum_q <= roll_sum;
                rolls <= sat_inc(rolls);
            end
            if (set_pt) begin
                point       <= sum_q;
                point_valid <= 1'b1;
            end
            if (book_win || book_lose) begin
                games <= sat_inc(games);
            end
            if (book_win) begin
                wins    <= sat_inc(wins);
                credits <= cred_win;
            end
            if (book_lose) begin
                losses  <= sat_inc(losses);
                credits <= cred_lose;
            end
            if (enter_idle) begin
                point       <= '0;
                point_valid <= 1'b0;
                rolls       <= '0;
            end
        end
    end

    assign state = state_q;

    always_comb begin
        play  = 1'b0;
        win   = 1'b0;
        lose  = 1'b0;
        broke = 1'b0;
        case (state_q)
            ST_CO_ROLL, ST_CO_EVAL, ST_PT_WAIT, ST_PT_ROLL,
            ST_PT_EVAL, ST_WIN_HOLD, ST_LOSE_HOLD: play  = 1'b1;
            ST_WIN:                                win   = 1'b1;
            ST_LOSE:                               lose  = 1'b1;
            ST_BROKE:                              broke = 1'b1;
            default:                               play  = 1'b0;
        endcase
    end

endmodule
